reset_sequencer: RTL and testbench

- Ordered reset-release controller placed between the clock/PLL front end and the design.
- Holds NSTAGES reset domains (e.g. BRAM/memory, CPU, peripherals) in reset until the PLL is locked and a BRAM warm-up interval has elapsed.
- Then releases the domains one at a time, in index order, each gated by the previous stage's ready handshake.
- Re-runs the whole sequence on a soft-reset request.

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/sync2.sv | 25 ++
 rtl/reset_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the ordered reset-release sequencer.
// State encoding, state width and default parameter values.
package reset_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK  = 3'd0,
    WARMUP     = 3'd1,
    RELEASE    = 3'd2,
    WAIT_READY = 3'd3,
    RUN        = 3'd4,
    ASSERT     = 3'd5
  } state_e;

  localparam int DEF_NSTAGES      = 3;
  localparam int DEF_WARMUP_BITS  = 16;
  localparam int DEF_GAP_CYCLES   = 16;
  localparam int DEF_TIMEOUT_BITS = 12;
  localparam int DEF_WD_BITS      = 20;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer with asynchronous active-high clear.
// Output lags the input by two clock edges.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller: lock, warm-up, per-stage release.
// Define RESET_SEQ_WATCHDOG_EN to add the RUN-state watchdog.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NSTAGES      = DEF_NSTAGES,
  parameter int WARMUP_BITS  = DEF_WARMUP_BITS,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
`ifdef RESET_SEQ_WATCHDOG_EN
  ,
  parameter int WD_BITS      = DEF_WD_BITS
`endif
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               pll_locked,
  input  logic [NSTAGES-1:0] stage_ready,
  input  logic               soft_req,
`ifdef RESET_SEQ_WATCHDOG_EN
  input  logic               wd_kick,
  output logic               wd_fired,
`endif
  output logic [NSTAGES-1:0] stage_resetn,
  output logic               all_released,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IDX_W = idx_w(NSTAGES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSTAGES - 1);
  localparam logic [WARMUP_BITS-1:0] W_MAX = '1;
  localparam logic [TIMEOUT_BITS-1:0] T_MAX = '1;
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [WARMUP_BITS-1:0]  wcnt_q, wcnt_d, wcnt_inc;
  logic [7:0]              gcnt_q, gcnt_d;
  logic [TIMEOUT_BITS-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_nxt;
  logic [NSTAGES-1:0]      rstn_q, rstn_d;
  logic                    all_q, all_d;
  logic                    busy_q, busy_d;
  logic                    terr_q, terr_d;
  logic                    lock_s;
  logic                    ready_now;
  logic                    go_assert;
  logic                    wd_fire;

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam logic [WD_BITS-1:0] WD_MAX = '1;
  logic [WD_BITS-1:0] wd_q, wd_d, wd_inc;
  logic               wdf_q, wdf_d;
`endif

  sync2 u_lock_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (pll_locked),
    .q   (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    gcnt_d    = gcnt_q;
    tcnt_d    = tcnt_q;
    idx_d     = idx_q;
    rstn_d    = rstn_q;
    all_d     = all_q;
    busy_d    = busy_q;
    terr_d    = terr_q;
    wcnt_inc  = (wcnt_q == W_MAX) ? W_MAX : wcnt_q + 1'b1;
    tcnt_inc  = tcnt_q + 1'b1;
    idx_nxt   = idx_q + 1'b1;
    ready_now = stage_ready[idx_q];
    go_assert = 1'b0;
    wd_fire   = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
    wd_d   = wd_q;
    wdf_d  = wdf_q;
    wd_inc = wd_kick ? '0 : wd_q + 1'b1;
`endif
    unique case (state_q)
      WAIT_LOCK: begin
        wcnt_d = '0;
        rstn_d = '0;
        if (lock_s) state_d = WARMUP;
      end
      WARMUP: begin
        if (!lock_s) begin
          wcnt_d  = '0;
          state_d = WAIT_LOCK;
        end else begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == W_MAX) begin
            state_d = RELEASE;
            idx_d   = '0;
            gcnt_d  = '0;
            rstn_d  = NSTAGES'(1);
          end
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          go_assert = 1'b1;
        end else if (gcnt_q == GAP_LAST) begin
          state_d = WAIT_READY;
          tcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      WAIT_READY: begin
        if (!lock_s) begin
          go_assert = 1'b1;
        end else begin
          tcnt_d = tcnt_inc;
          // A missing ready only flags an error; the sequence still moves on.
          if (ready_now || tcnt_inc == T_MAX) begin
            if (!ready_now) terr_d = 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              all_d   = 1'b1;
              busy_d  = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
              wd_d    = '0;
`endif
            end else begin
              state_d = RELEASE;
              idx_d   = idx_nxt;
              gcnt_d  = '0;
              rstn_d  = rstn_q | (NSTAGES'(1) << idx_nxt);
            end
          end
        end
      end
      RUN: begin
`ifdef RESET_SEQ_WATCHDOG_EN
        wd_d    = wd_inc;
        wd_fire = (wd_inc == WD_MAX);
        if (wd_fire) wdf_d = 1'b1;
`endif
        if (!lock_s || soft_req || wd_fire) go_assert = 1'b1;
      end
      ASSERT: state_d = WAIT_LOCK;
      default: begin
        state_d = WAIT_LOCK;
        rstn_d  = '0;
        all_d   = 1'b0;
        busy_d  = 1'b1;
      end
    endcase
    if (go_assert) begin
      state_d = ASSERT;
      rstn_d  = '0;
      all_d   = 1'b0;
      busy_d  = 1'b1;
      wcnt_d  = '0;
      gcnt_d  = '0;
      tcnt_d  = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= WAIT_LOCK;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
      rstn_q  <= '0;
      all_q   <= 1'b0;
      busy_q  <= 1'b1;
      terr_q  <= 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
      wd_q    <= '0;
      wdf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      rstn_q  <= rstn_d;
      all_q   <= all_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
`ifdef RESET_SEQ_WATCHDOG_EN
      wd_q    <= wd_d;
      wdf_q   <= wdf_d;
`endif
    end
  end

  assign stage_resetn = rstn_q;
  assign all_released = all_q;
  assign busy         = busy_q;
  assign timeout_err  = terr_q;
`ifdef RESET_SEQ_WATCHDOG_EN
  assign wd_fired     = wdf_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with a 4-bit warm-up and 2-cycle gap.
// Watchdog scenario runs only when RESET_SEQ_WATCHDOG_EN is defined.
module tb_reset_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_req = 1'b0;
  logic [2:0] stage_ready = 3'b111;
  logic [2:0] stage_resetn;
  logic       all_released;
  logic       busy;
  logic       timeout_err;
`ifdef RESET_SEQ_WATCHDOG_EN
  logic       wd_kick = 1'b0;
  logic       wd_fired;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  reset_sequencer #(
    .NSTAGES      (3),
    .WARMUP_BITS  (4),
    .GAP_CYCLES   (2),
    .TIMEOUT_BITS (3)
`ifdef RESET_SEQ_WATCHDOG_EN
    ,
    .WD_BITS      (4)
`endif
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .pll_locked   (pll_locked),
    .stage_ready  (stage_ready),
    .soft_req     (soft_req),
`ifdef RESET_SEQ_WATCHDOG_EN
    .wd_kick      (wd_kick),
    .wd_fired     (wd_fired),
`endif
    .stage_resetn (stage_resetn),
    .all_released (all_released),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Edge numbering from the drive point E0+1: lock_s at E2, WARMUP at E3,
  // 15 warm-up edges E4..E18, then releases at E18, E21, E24 and RUN at E27.
  task automatic check_seq(input string nm, input int done);
    tick(17 - done);
    n_tests++;
    if (stage_resetn !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_hold: stage_resetn=%b want 000", nm, stage_resetn);
    end
    tick(1);
    n_tests++;
    if (stage_resetn !== 3'b001) begin
      n_fail++;
      $display("FAIL %s_rel0: stage_resetn=%b want 001", nm, stage_resetn);
    end
    tick(2);
    n_tests++;
    if (stage_resetn !== 3'b001) begin
      n_fail++;
      $display("FAIL %s_gap0: stage_resetn=%b want 001", nm, stage_resetn);
    end
    tick(1);
    n_tests++;
    if (stage_resetn !== 3'b011) begin
      n_fail++;
      $display("FAIL %s_rel1: stage_resetn=%b want 011", nm, stage_resetn);
    end
    tick(3);
    n_tests++;
    if (stage_resetn !== 3'b111 || all_released !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_rel2: resetn=%b all=%b want 111/0", nm, stage_resetn, all_released);
    end
    tick(2);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_prerun: busy=%b want 1", nm, busy);
    end
    tick(1);
    n_tests++;
    if (all_released !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_run: all=%b busy=%b want 1/0", nm, all_released, busy);
    end
  endtask

  task automatic test_reset();
    tick(1);
    n_tests++;
    if (stage_resetn !== 3'b000 || all_released !== 1'b0 ||
        busy !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: resetn=%b all=%b busy=%b terr=%b want 000/0/1/0",
               stage_resetn, all_released, busy, timeout_err);
    end
  endtask

  task automatic test_power_up();
    RESET = 1'b0;
    pll_locked = 1'b1;
    check_seq("pwr", 0);
  endtask

  task automatic test_ready_timeout();
    stage_ready = 3'b101;
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    tick(20);
    n_tests++;
    if (stage_resetn !== 3'b011) begin
      n_fail++;
      $display("FAIL to_rel1: stage_resetn=%b want 011", stage_resetn);
    end
    // WAIT_READY entered at E23; seven waiting edges E24..E30.
    tick(8);
    n_tests++;
    if (stage_resetn !== 3'b011 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_wait: resetn=%b terr=%b want 011/0", stage_resetn, timeout_err);
    end
    tick(1);
    n_tests++;
    if (stage_resetn !== 3'b111 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_fire: resetn=%b terr=%b want 111/1", stage_resetn, timeout_err);
    end
    tick(3);
    n_tests++;
    if (all_released !== 1'b1 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_run: all=%b terr=%b want 1/1", all_released, timeout_err);
    end
    stage_ready = 3'b111;
  endtask

  task automatic test_soft_reset();
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    n_tests++;
    if (stage_resetn !== 3'b000 || busy !== 1'b1 || all_released !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_assert: resetn=%b busy=%b all=%b want 000/1/0",
               stage_resetn, busy, all_released);
    end
    check_seq("soft", 1);
    n_tests++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL soft_terr: timeout_err=%b want 1", timeout_err);
    end
  endtask

  task automatic test_lock_loss();
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    tick(20);
    pll_locked = 1'b0;
    tick(2);
    n_tests++;
    if (stage_resetn !== 3'b011) begin
      n_fail++;
      $display("FAIL lock_sync: stage_resetn=%b want 011", stage_resetn);
    end
    tick(1);
    n_tests++;
    if (stage_resetn !== 3'b000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_drop: resetn=%b busy=%b want 000/1", stage_resetn, busy);
    end
    tick(2);
    pll_locked = 1'b1;
    check_seq("relock", 0);
  endtask

  task automatic test_async_reset();
    stage_ready = 3'b011;
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    tick(23);
    n_tests++;
    if (stage_resetn !== 3'b111) begin
      n_fail++;
      $display("FAIL arst_rel2: stage_resetn=%b want 111", stage_resetn);
    end
    tick(4);
    n_tests++;
    if (timeout_err !== 1'b1 || all_released !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_wait: terr=%b all=%b want 1/0", timeout_err, all_released);
    end
    #2;
    RESET = 1'b1;
    #1;
    n_tests++;
    if (stage_resetn !== 3'b000 || timeout_err !== 1'b0 ||
        busy !== 1'b1 || all_released !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_now: resetn=%b terr=%b busy=%b all=%b want 000/0/1/0",
               stage_resetn, timeout_err, busy, all_released);
    end
    stage_ready = 3'b111;
    tick(1);
    RESET = 1'b0;
    check_seq("post_rst", 0);
  endtask

`ifdef RESET_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    tick(14);
    n_tests++;
    if (all_released !== 1'b1 || wd_fired !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_pre: all=%b wd=%b want 1/0", all_released, wd_fired);
    end
    tick(1);
    n_tests++;
    if (stage_resetn !== 3'b000 || wd_fired !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_fire: resetn=%b wd=%b busy=%b want 000/1/1",
               stage_resetn, wd_fired, busy);
    end
    check_seq("wd_replay", 1);
    for (int k = 0; k < 4; k++) begin
      tick(9);
      n_tests++;
      if (all_released !== 1'b1) begin
        n_fail++;
        $display("FAIL wd_kick%0d: all_released=%b want 1", k, all_released);
      end
      wd_kick = 1'b1;
      tick(1);
      wd_kick = 1'b0;
    end
    n_tests++;
    if (wd_fired !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_sticky: wd_fired=%b want 1", wd_fired);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_power_up();
    test_ready_timeout();
    test_soft_reset();
    test_lock_loss();
    test_async_reset();
`ifdef RESET_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
